pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Holds the architectural program counter and consumes the 2-bit PC-source code and 32-bit next-PC target from the next-PC logic.
- Fetches one instruction per PC from instruction memory over a req/ack handshake, presents it to decode, and commits the PC update when decode is not stalled.
- Also holds EPC for exception entry and `eret` return.
- Sits between the next-PC logic and the instruction memory port of the unpipelined core.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded on exception (pcsrc 2'b11).

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_pcsrc  in  2  00 sequential, 01 branch/jump/jr target, 10 eret, 11 exception.
- i_nextpc  in  32  target address, used when i_pcsrc=01.
- i_stall  in  1  decode/execute not ready; hold the current instruction.
- i_imem_ack  in  1  instruction memory data valid this cycle.
- i_imem_rdata  in  32  instruction word, valid with i_imem_ack.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  fetch address (= o_pc).
- o_instr  out  32  latched instruction.
- o_instr_valid  out  1  o_instr is valid for execution this cycle.
- o_pc  out  32  address of the current instruction.
- o_pc_plus4  out  32  o_pc + 4, combinational; feeds the next-PC adder.
- o_epc  out  32  exception return address.

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous, active-low, i_rst_n. All state updates on the rising i_clk edge.
- Reset values: pc=RESET_VECTOR, epc=0, o_instr=0, o_instr_valid=0, o_imem_req=0, state=S_IDLE.
- FSM:
  - S_IDLE: outputs inactive. Next cycle goes to S_REQ unconditionally (one bubble after reset).
  - S_REQ: o_imem_req=1, o_imem_addr=pc. Remains here until i_imem_ack=1. On ack: o_instr<=i_imem_rdata, go to S_EXEC. Ack can arrive in the first cycle req is high, giving a minimum latency of 1 cycle.
  - S_EXEC: o_instr_valid=1, o_imem_req=0.
    - If i_stall=1: hold pc, o_instr and state.
    - If i_stall=0: commit the PC update below and go to S_REQ.
- PC update, on commit only (i_pcsrc is ignored in other states or while stalled):
  - 00: pc<=pc+4.
  - 01: pc<={i_nextpc[31:2],2'b00}. The low two bits are forced to zero.
  - 10: pc<=epc.
  - 11: pc<=EXC_VECTOR and epc<=pc+4 (resume address).
- epc changes only on an exception commit. An eret commit does not modify epc.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- o_imem_addr and o_pc are both the registered pc. They are stable for the whole S_REQ/S_EXEC window.
- An ack seen outside S_REQ is ignored, including a late ack after reset. rdata is not sampled.
- Reset mid-fetch or mid-stall: return to S_IDLE next edge. req drops, o_instr_valid drops, pc=RESET_VECTOR, pending ack is discarded.
- Throughput: at most one instruction per 2 cycles (REQ+EXEC) with zero-wait memory.

Decomposition:
- Shared package `core_pkg` holds:
  - PCSRC_SEQ=2'b00, PCSRC_JMP=2'b01, PCSRC_ERET=2'b10, PCSRC_EXC=2'b11.
  - FSM state encoding S_IDLE/S_REQ/S_EXEC (2-bit).
  - Default RESET_VECTOR/EXC_VECTOR constants.
- One natural sub-module is `pc_sel_mux`: a combinational 4:1 select of {pc+4, aligned target, epc, EXC_VECTOR} on i_pcsrc. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset then zero-wait ack, pcsrc=00, no stall: fetch addresses are 0x0, 0x4, 0x8. o_instr_valid pulses every second cycle. o_pc_plus4 is 0x4 while pc=0x0.
- At pc=0x10, pcsrc=01, i_nextpc=0x0000_0123: next fetch address is 0x0000_0120. epc is unchanged.
- At pc=0x40, pcsrc=11: next address is 0x180 and o_epc=0x44. Then at pc=0x184, pcsrc=10: next address is 0x44 and o_epc stays 0x44.
- Ack delayed 3 cycles: o_imem_req stays high with a constant address for 4 cycles and o_instr_valid stays 0. Then i_stall=1 for 5 cycles in S_EXEC with pcsrc toggling: pc and o_instr hold. The update applies only in the cycle i_stall falls.
- i_rst_n low during S_REQ at pc=0x200, with ack arriving in the cycle after reset: pc=RESET_VECTOR, o_imem_req=0, o_instr unchanged from its reset value 0. The first post-reset fetch is at 0x0.
- pc=0xFFFF_FFFC, pcsrc=00: next fetch address is 0x0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core's fetch stage: PC-source codes, fetch FSM
// state encoding and the default reset/exception vectors.
package core_pkg;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JMP  = 2'b01;
    localparam logic [1:0] PCSRC_ERET = 2'b10;
    localparam logic [1:0] PCSRC_EXC  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_EXEC = 2'b10
    } fetch_state_t;

    // Instruction addresses are word aligned, so the low two bits are cleared.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_sel_mux.sv
// Next-PC selector: picks the candidate PC for the next commit based on the
// PC-source code from the next-PC logic.
module pc_sel_mux
    import core_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] nextpc,
    input  logic [31:0] epc,
    output logic [31:0] next_pc
);

    // Four-way select of sequential, aligned target, return and trap addresses.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc)
            PCSRC_SEQ:  next_pc = pc_plus4;
            PCSRC_JMP:  next_pc = align_word(nextpc);
            PCSRC_ERET: next_pc = epc;
            PCSRC_EXC:  next_pc = EXC_VECTOR;
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch unit for the unpipelined core.
// Fetches one instruction per PC over a req/ack port, holds it for decode
// until it is no longer stalled, then commits the next PC and EPC.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_pcsrc,
    input  logic [31:0] i_nextpc,
    input  logic        i_stall,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_epc
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  epc;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc + 32'd4;

    pc_sel_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_sel_mux (
        .pcsrc    (i_pcsrc),
        .pc_plus4 (pc_plus4),
        .nextpc   (i_nextpc),
        .epc      (epc),
        .next_pc  (next_pc)
    );

    // Fetch FSM with registered handshake/valid outputs; PC and EPC change only on commit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_VECTOR;
            epc           <= 32'h0000_0000;
            o_instr       <= 32'h0000_0000;
            o_instr_valid <= 1'b0;
            o_imem_req    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_imem_req <= 1'b1;
                    state      <= S_REQ;
                end
                S_REQ: begin
                    if (i_imem_ack) begin
                        o_instr       <= i_imem_rdata;
                        o_instr_valid <= 1'b1;
                        o_imem_req    <= 1'b0;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!i_stall) begin
                        pc <= next_pc;
                        if (i_pcsrc == PCSRC_EXC) begin
                            epc <= pc_plus4;
                        end
                        o_instr_valid <= 1'b0;
                        o_imem_req    <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                default: begin
                    o_instr_valid <= 1'b0;
                    o_imem_req    <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pc        = pc;
    assign o_imem_addr = pc;
    assign o_pc_plus4  = pc_plus4;
    assign o_epc       = epc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: sequential fetch, jump
// alignment, exception/eret, delayed ack, stall hold, reset mid-fetch and
// PC wraparound.
module tb_pc_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_pcsrc;
    logic [31:0] i_nextpc;
    logic        i_stall;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_epc;

    int vectors = 0;
    int miscompares = 0;

    pc_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pcsrc       (i_pcsrc),
        .i_nextpc      (i_nextpc),
        .i_stall       (i_stall),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_epc         (o_epc)
    );

    // Free-running core clock.
    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Fetch at exp_addr; ack is withheld for wait_cycles cycles before being given.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int wait_cycles);
        for (int w = 0; w < wait_cycles; w++) begin
            check("wait_req",   {31'd0, o_imem_req},    32'd1);
            check("wait_addr",  o_imem_addr,            exp_addr);
            check("wait_valid", {31'd0, o_instr_valid}, 32'd0);
            tick();
        end
        check("req",      {31'd0, o_imem_req},    32'd1);
        check("req_addr", o_imem_addr,            exp_addr);
        check("req_pc",   o_pc,                   exp_addr);
        check("req_plus4", o_pc_plus4,            exp_addr + 32'd4);
        check("req_valid", {31'd0, o_instr_valid}, 32'd0);
        i_imem_ack   = 1'b1;
        i_imem_rdata = word;
        tick();
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'hDEAD_BEEF;
        check("exec_valid", {31'd0, o_instr_valid}, 32'd1);
        check("exec_instr", o_instr,                word);
        check("exec_req",   {31'd0, o_imem_req},    32'd0);
        check("exec_pc",    o_pc,                   exp_addr);
    endtask

    // Commit from S_EXEC with the given PC source.
    task automatic commit(input logic [1:0] src, input logic [31:0] target);
        i_pcsrc  = src;
        i_nextpc = target;
        i_stall  = 1'b0;
        tick();
        i_pcsrc  = 2'b00;
        i_nextpc = 32'h0;
        check("commit_valid", {31'd0, o_instr_valid}, 32'd0);
        check("commit_req",   {31'd0, o_imem_req},    32'd1);
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_pcsrc      = 2'b00;
        i_nextpc     = 32'h0;
        i_stall      = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'h0;
        tick();
        tick();

        // Reset state.
        check("rst_pc",    o_pc,                   32'h0);
        check("rst_epc",   o_epc,                  32'h0);
        check("rst_instr", o_instr,                32'h0);
        check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        check("rst_req",   {31'd0, o_imem_req},    32'd0);

        // Release reset: one idle bubble, then request at 0x0.
        i_rst_n = 1'b1;
        check("idle_req", {31'd0, o_imem_req}, 32'd0);
        tick();

        // Sequential zero-wait fetches.
        fetch(32'h0000_0000, 32'h1111_0000, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_0004, 32'h1111_0004, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_0008, 32'h1111_0008, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_000C, 32'h1111_000C, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_0010, 32'h1111_0010, 0);

        // Jump with unaligned target; EPC untouched.
        commit(2'b01, 32'h0000_0123);
        check("jmp_epc", o_epc, 32'h0);
        fetch(32'h0000_0120, 32'h2222_0120, 0);

        // Exception at 0x40, then eret from 0x184.
        commit(2'b01, 32'h0000_0040);
        fetch(32'h0000_0040, 32'h3333_0040, 0);
        commit(2'b11, 32'h0000_0999);
        check("exc_epc", o_epc, 32'h0000_0044);
        fetch(32'h0000_0180, 32'h3333_0180, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_0184, 32'h3333_0184, 0);
        commit(2'b10, 32'h0000_0999);
        check("eret_epc", o_epc, 32'h0000_0044);
        fetch(32'h0000_0044, 32'h3333_0044, 0);

        // Delayed ack, then stall with a toggling PC source.
        commit(2'b00, 32'h0);
        fetch(32'h0000_0048, 32'h4444_0048, 3);
        i_stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            i_pcsrc  = 2'(s);
            i_nextpc = 32'h0000_0300 + 32'(s * 4);
            tick();
            check("stall_pc",    o_pc,                   32'h0000_0048);
            check("stall_instr", o_instr,                32'h4444_0048);
            check("stall_valid", {31'd0, o_instr_valid}, 32'd1);
            check("stall_req",   {31'd0, o_imem_req},    32'd0);
            check("stall_epc",   o_epc,                  32'h0000_0044);
        end
        commit(2'b01, 32'h0000_0200);
        check("unstall_pc", o_pc, 32'h0000_0200);

        // Reset while requesting at 0x200; ack arrives the cycle after reset.
        check("pre_rst_addr", o_imem_addr, 32'h0000_0200);
        i_rst_n = 1'b0;
        tick();
        check("mid_rst_pc",    o_pc,                   32'h0);
        check("mid_rst_req",   {31'd0, o_imem_req},    32'd0);
        check("mid_rst_valid", {31'd0, o_instr_valid}, 32'd0);
        check("mid_rst_instr", o_instr,                32'h0);
        check("mid_rst_epc",   o_epc,                  32'h0);
        i_rst_n      = 1'b1;
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hBAD0_BAD0;
        tick();
        i_imem_ack   = 1'b0;
        check("late_ack_instr", o_instr,                32'h0);
        check("late_ack_valid", {31'd0, o_instr_valid}, 32'd0);
        check("late_ack_req",   {31'd0, o_imem_req},    32'd1);
        fetch(32'h0000_0000, 32'h5555_0000, 0);

        // PC wraparound at the top of the address space.
        commit(2'b01, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h6666_FFFC, 0);
        commit(2'b00, 32'h0);
        fetch(32'h0000_0000, 32'h6666_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
